egr_dpb_pod_unpacker: RTL and testbench

- Egress-side receiver for dirty pods sent by the IGR Dirty Pod Manager.
- Each pod carries up to POD_PTRS dirty segment pointers. The block buffers whole pods in a small FIFO and serialises them into a single-pointer valid/ready stream.
- That stream feeds the Dirty Pointer Broker's pointer-request path, i.e. it sits in place of the PFS side of the broker.
- Upstream flow control is credit-based: one credit per FIFO pod slot.

---
 rtl/egr_dpb_pod_unpacker.sv | 99 +++++++++
 tb/tb_egr_dpb_pod_unpacker.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/egr_dpb_pod_unpacker.sv
// rtl/egr_dpb_pod_unpacker.sv - buffers dirty pods and serialises them into a single-pointer stream
// Pod credits are returned upstream on every pop and on every dropped illegal-count pod.
module egr_dpb_pod_unpacker #(
  parameter int PTR_W          = 20,
  parameter int POD_PTRS       = 8,
  parameter int POD_FIFO_DEPTH = 4,
  parameter int CNT_W          = $clog2(POD_PTRS) + 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              pod_valid,
  input  logic [POD_PTRS*PTR_W-1:0]         pod_ptrs,
  input  logic [CNT_W-1:0]                  pod_cnt,
  output logic                              pod_credit_ret,
  output logic                              ptr_valid,
  output logic [PTR_W-1:0]                  ptr,
  input  logic                              ptr_ready,
  output logic [$clog2(POD_FIFO_DEPTH):0]   fifo_level,
  output logic                              ovfl_err,
  output logic                              cnt_err
);

  localparam int AW = $clog2(POD_FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = (AW + 2 > 3) ? AW + 2 : 3;

  logic [POD_PTRS*PTR_W-1:0] mem_ptrs [POD_FIFO_DEPTH];
  logic [CNT_W-1:0]          mem_cnt  [POD_FIFO_DEPTH];

  logic [AW-1:0]             wr_ptr, rd_ptr;
  logic [CNT_W-1:0]          idx;
  logic [PW-1:0]             pending, avail;
  logic [POD_PTRS*PTR_W-1:0] head_ptrs;
  logic [CNT_W-1:0]          head_cnt;
  logic empty, full, cnt_ok, accept, last, pop, push, ovfl_evt, cnt_bad;

  assign empty     = (fifo_level == '0);
  assign full      = (fifo_level == LW'(POD_FIFO_DEPTH));
  assign cnt_ok    = (pod_cnt != '0) && (pod_cnt <= CNT_W'(POD_PTRS));
  assign head_ptrs = mem_ptrs[rd_ptr];
  assign head_cnt  = mem_cnt[rd_ptr];

  assign ptr_valid = !empty;
  assign accept    = ptr_valid && ptr_ready;
  assign last      = (idx == head_cnt - 1'b1);
  assign pop       = accept && last;
  // A full FIFO still takes a pod when the head leaves in the same cycle.
  assign push      = pod_valid && cnt_ok && (!full || pop);
  assign ovfl_evt  = pod_valid && cnt_ok && full && !pop;
  assign cnt_bad   = pod_valid && !cnt_ok;
  assign avail     = pending + PW'(pop) + PW'(cnt_bad);

  always_comb begin
    ptr = '0;
    if (!empty) begin
      for (int i = 0; i < POD_PTRS; i++) begin
        if (idx == CNT_W'(i)) ptr = head_ptrs[i*PTR_W +: PTR_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_ptrs[wr_ptr] <= pod_ptrs;
      mem_cnt[wr_ptr]  <= pod_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_level     <= '0;
      idx            <= '0;
      pending        <= '0;
      pod_credit_ret <= 1'b0;
      ovfl_err       <= 1'b0;
      cnt_err        <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
      if (accept) idx <= last ? '0 : idx + 1'b1;
      // One credit leaves per cycle; the rest wait in pending.
      pod_credit_ret <= (avail != '0);
      pending        <= avail - PW'(avail != '0);
      if (ovfl_evt) ovfl_err <= 1'b1;
      if (cnt_bad)  cnt_err  <= 1'b1;
    end
  end

  a_hold_under_backpressure: assert property (@(posedge clk) disable iff (!rst_n)
    ptr_valid && !ptr_ready |=> ptr_valid && $stable(ptr));
  a_level_bound: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_level <= LW'(POD_FIFO_DEPTH));
  a_ptr_known: assert property (@(posedge clk) disable iff (!rst_n)
    ptr_valid |-> !$isunknown(ptr));

endmodule

// File: tb/tb_egr_dpb_pod_unpacker.sv
// tb/tb_egr_dpb_pod_unpacker.sv - queue-model bench for egr_dpb_pod_unpacker
module tb_egr_dpb_pod_unpacker;

  localparam int PTR_W    = 20;
  localparam int POD_PTRS = 8;
  localparam int DEPTH    = 4;
  localparam int CNT_W    = 4;
  localparam int LW       = 3;

  typedef logic [POD_PTRS-1:0][PTR_W-1:0] ptrs_t;
  typedef struct packed {
    ptrs_t            p;
    logic [CNT_W-1:0] cnt;
  } pod_t;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      pod_valid;
  logic [POD_PTRS*PTR_W-1:0] pod_ptrs;
  logic [CNT_W-1:0]          pod_cnt;
  logic                      pod_credit_ret;
  logic                      ptr_valid;
  logic [PTR_W-1:0]          ptr;
  logic                      ptr_ready;
  logic [LW-1:0]             fifo_level;
  logic                      ovfl_err;
  logic                      cnt_err;

  egr_dpb_pod_unpacker #(
    .PTR_W(PTR_W), .POD_PTRS(POD_PTRS), .POD_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pod_valid(pod_valid), .pod_ptrs(pod_ptrs),
    .pod_cnt(pod_cnt), .pod_credit_ret(pod_credit_ret), .ptr_valid(ptr_valid),
    .ptr(ptr), .ptr_ready(ptr_ready), .fifo_level(fifo_level),
    .ovfl_err(ovfl_err), .cnt_err(cnt_err)
  );

  always #5 clk = ~clk;

  pod_t q[$];
  int   m_idx, owed, credits;
  bit   m_ovfl, m_cerr;
  int   compared = 0;
  int   mismatched = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ptrs_t rand_ptrs();
    ptrs_t r;
    for (int i = 0; i < POD_PTRS; i++) r[i] = PTR_W'($urandom);
    return r;
  endfunction

  // One clock: compare outputs with the model, then drive inputs and advance the model.
  task automatic cycle(input bit pv, input logic [CNT_W-1:0] cnt, input ptrs_t ptrs, input bit rdy);
    int   ev;
    bit   popped, pushed;
    pod_t np;
    @(negedge clk);
    check_eq("ptr_valid", ptr_valid, q.size() > 0);
    if (q.size() > 0) check_eq("ptr", ptr, q[0].p[m_idx]);
    check_eq("fifo_level", fifo_level, q.size());
    check_eq("credit_ret", pod_credit_ret, owed > 0);
    check_eq("ovfl_err", ovfl_err, m_ovfl);
    check_eq("cnt_err", cnt_err, m_cerr);
    if (pod_credit_ret) credits++;
    pod_valid = pv; pod_cnt = cnt; pod_ptrs = ptrs; ptr_ready = rdy;
    ev = 0; popped = 0; pushed = 0;
    if (q.size() > 0 && rdy) begin
      if (m_idx == int'(q[0].cnt) - 1) popped = 1;
      else m_idx++;
    end
    if (pv) begin
      if (cnt == 0 || cnt > POD_PTRS) begin m_cerr = 1; ev++; end
      else if (q.size() < DEPTH || popped) pushed = 1;
      else m_ovfl = 1;
    end
    if (popped) begin void'(q.pop_front()); m_idx = 0; ev++; end
    if (pushed) begin np.p = ptrs; np.cnt = cnt; q.push_back(np); end
    owed = owed - (owed > 0 ? 1 : 0) + ev;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(0, '0, '0, rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; pod_valid = 0; pod_cnt = '0; pod_ptrs = '0; ptr_ready = 0;
    #1;
    check_eq("rst_ptr_valid", ptr_valid, 0);
    check_eq("rst_ptr", ptr, 0);
    check_eq("rst_level", fifo_level, 0);
    check_eq("rst_credit", pod_credit_ret, 0);
    check_eq("rst_ovfl", ovfl_err, 0);
    check_eq("rst_cnt_err", cnt_err, 0);
    q.delete(); m_idx = 0; owed = 0; m_ovfl = 0; m_cerr = 0; credits = DEPTH;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    ptrs_t p3;
    bit rdy_seq [5] = '{0, 0, 1, 0, 1};
    rst_n = 1'b0; pod_valid = 0; pod_cnt = '0; pod_ptrs = '0; ptr_ready = 0;
    do_reset();

    // Single pod of three pointers, consumer always ready.
    p3 = rand_ptrs(); p3[0] = 20'h11; p3[1] = 20'h22; p3[2] = 20'h33;
    cycle(1, 3, p3, 1);
    idle(6, 1);

    // Two-pointer pod under a stalling consumer.
    cycle(1, 2, rand_ptrs(), 0);
    for (int i = 0; i < 5; i++) cycle(0, '0, '0, rdy_seq[i]);
    idle(4, 1);

    // Full FIFO with a push landing on the cycle the head leaves.
    for (int i = 0; i < DEPTH; i++) cycle(1, 1, rand_ptrs(), 0);
    cycle(0, '0, '0, 0);
    cycle(1, 2, rand_ptrs(), 1);
    idle(10, 1);

    // Full FIFO overflow: 4 x 8 pointers held back, then a fifth pod.
    for (int i = 0; i < DEPTH; i++) cycle(1, 8, rand_ptrs(), 0);
    cycle(1, 8, rand_ptrs(), 0);
    idle(3, 0);
    idle(40, 1);

    // Illegal counts.
    cycle(1, 0, rand_ptrs(), 1);
    cycle(1, 9, rand_ptrs(), 1);
    idle(5, 1);

    // Randomised traffic respecting upstream credits.
    credits = DEPTH;
    for (int n = 0; n < 3000; n++) begin
      bit pv;
      logic [CNT_W-1:0] c;
      pv = (credits > 0) && ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) c = ($urandom_range(0, 1) == 0) ? 4'd0 : CNT_W'($urandom_range(9, 15));
      else c = CNT_W'($urandom_range(1, POD_PTRS));
      if (pv) credits--;
      cycle(pv, c, rand_ptrs(), $urandom_range(0, 3) != 0);
    end
    idle(60, 1);

    // Reset in the middle of an eight-pointer pod.
    do_reset();
    cycle(1, 8, rand_ptrs(), 0);
    while (m_idx != 5) cycle(0, '0, '0, 1);
    do_reset();
    cycle(1, 1, rand_ptrs(), 1);
    idle(5, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
